// File: rtl/pipe_pkg.sv
// Shared pipeline-buffer definitions: default field widths and the E/M
// field offsets that stage wrappers use to slice ctrl/data/tag buses.
package pipe_pkg;

    localparam int unsigned CTRL_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 96;
    localparam int unsigned TAG_W_DEF  = 12;

    // E/M control-bit positions
    localparam int unsigned EM_CTRL_PCSRC    = 0;
    localparam int unsigned EM_CTRL_REGWRITE = 1;
    localparam int unsigned EM_CTRL_MEMWRITE = 2;
    localparam int unsigned EM_CTRL_MEMTOREG = 3;

    // E/M data-word positions (three 32-bit words)
    localparam int unsigned EM_WORD_W         = 32;
    localparam int unsigned EM_DATA_ALUOUT    = 0;
    localparam int unsigned EM_DATA_WRITEDATA = 32;
    localparam int unsigned EM_DATA_RD2       = 64;

    // E/M register-tag positions (three 4-bit tags)
    localparam int unsigned EM_REG_W   = 4;
    localparam int unsigned EM_TAG_WA3 = 0;
    localparam int unsigned EM_TAG_RA1 = 4;
    localparam int unsigned EM_TAG_RA2 = 8;

    // Default-width entry payload as seen by stage wrappers
    typedef struct packed {
        logic [CTRL_W_DEF-1:0] ctrl;
        logic [DATA_W_DEF-1:0] data;
        logic [TAG_W_DEF-1:0]  tag;
    } em_entry_t;

    // Number of valid entries held
    function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
        return 2'(main_v) + 2'(skid_v);
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid + ctrl + data + tag register.
// Ports: clk_i/rst_i (async active-high), load_i captures the inputs and sets
// valid, clear_i (priority) drops valid and zeroes ctrl; data/tag are kept.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [TAG_W-1:0]  tag_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;
    logic [TAG_W-1:0]  tag_q;

    // Clearing zeroes ctrl so an empty entry is always a harmless bubble
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
            tag_q   <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
            tag_q   <= tag_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline-stage buffer with valid/ready handshake, stall, flush to
// bubble and optional 2-entry skid (SKID=1) giving a registered in_ready.
// Ports: CLK/RESET (async active-high); upstream in_valid/in_ready/in_ctrl/
// in_data/in_tag; flush; downstream out_valid/out_ready/out_ctrl/out_data/
// out_tag; occupancy = number of held entries.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF,
    parameter int unsigned SKID   = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic [1:0]        occupancy
);

    logic              main_v, skid_v;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [TAG_W-1:0]  main_tag, skid_tag;

    logic accept, drain, main_free;
    logic main_load, main_clr, main_from_skid;
    logic skid_load, skid_clr;
    logic main_v_d, skid_v_d;
    logic [1:0] occ_q;

    logic [CTRL_W-1:0] main_ctrl_in;
    logic [DATA_W-1:0] main_data_in;
    logic [TAG_W-1:0]  main_tag_in;

    // Entry movement: flush wins, then refill main from skid before input
    always_comb begin
        accept         = in_valid && in_ready;
        drain          = main_v && out_ready;
        main_free      = !main_v || drain;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        main_v_d       = main_v;
        skid_v_d       = skid_v;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (SKID != 0) begin
            if (main_free) begin
                if (skid_v) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    main_v_d       = 1'b1;
                    skid_load      = accept;
                    skid_clr       = !accept;
                    skid_v_d       = accept;
                end else if (accept) begin
                    main_load = 1'b1;
                    main_v_d  = 1'b1;
                end else if (main_v) begin
                    main_clr = 1'b1;
                    main_v_d = 1'b0;
                end
            end else if (accept) begin
                skid_load = 1'b1;
                skid_v_d  = 1'b1;
            end
        end else begin
            if (accept) begin
                main_load = 1'b1;
                main_v_d  = 1'b1;
            end else if (drain) begin
                main_clr = 1'b1;
                main_v_d = 1'b0;
            end
        end
    end

    always_comb begin
        main_ctrl_in = in_ctrl;
        main_data_in = in_data;
        main_tag_in  = in_tag;
        if (main_from_skid) begin
            main_ctrl_in = skid_ctrl;
            main_data_in = skid_data;
            main_tag_in  = skid_tag;
        end
    end

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_main (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .load_i  (main_load),
        .clear_i (main_clr),
        .ctrl_i  (main_ctrl_in),
        .data_i  (main_data_in),
        .tag_i   (main_tag_in),
        .valid_o (main_v),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data),
        .tag_o   (main_tag)
    );

    if (SKID != 0) begin : g_skid
        logic in_ready_q;

        pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_skid (
            .clk_i   (CLK),
            .rst_i   (RESET),
            .load_i  (skid_load),
            .clear_i (skid_clr),
            .ctrl_i  (in_ctrl),
            .data_i  (in_data),
            .tag_i   (in_tag),
            .valid_o (skid_v),
            .ctrl_o  (skid_ctrl),
            .data_o  (skid_data),
            .tag_o   (skid_tag)
        );

        // Upstream ready is the registered complement of the next skid valid
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) in_ready_q <= 1'b1;
            else       in_ready_q <= !skid_v_d;
        end

        assign in_ready = in_ready_q;
    end else begin : g_noskid
        assign skid_v    = 1'b0;
        assign skid_ctrl = '0;
        assign skid_data = '0;
        assign skid_tag  = '0;
        assign in_ready  = out_ready || !main_v;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) occ_q <= 2'd0;
        else       occ_q <= occ_count(main_v_d, skid_v_d);
    end

    assign out_valid = main_v;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign out_tag   = main_tag;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: one SKID=1 and one SKID=0 instance, directed
// scenarios plus random traffic against a queue-based reference model.
module tb_pipe_stage_buffer;

    localparam int unsigned CW = 4;
    localparam int unsigned DW = 96;
    localparam int unsigned TW = 12;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic [TW-1:0] t;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic [TW-1:0] in_tag;

    logic iv1, ir1, fl1, ov1, or1;
    logic [CW-1:0] oc1;
    logic [DW-1:0] od1;
    logic [TW-1:0] ot1;
    logic [1:0]    occ1;

    logic iv0, ir0, fl0, ov0, or0;
    logic [CW-1:0] oc0;
    logic [DW-1:0] od0;
    logic [TW-1:0] ot0;
    logic [1:0]    occ0;

    ent_t m1[$];
    ent_t m0[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .TAG_W(TW), .SKID(1)) u_dut1 (
        .CLK(clk), .RESET(rst),
        .in_valid(iv1), .in_ready(ir1), .in_ctrl(in_ctrl), .in_data(in_data), .in_tag(in_tag),
        .flush(fl1),
        .out_valid(ov1), .out_ready(or1), .out_ctrl(oc1), .out_data(od1), .out_tag(ot1),
        .occupancy(occ1)
    );

    pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .TAG_W(TW), .SKID(0)) u_dut0 (
        .CLK(clk), .RESET(rst),
        .in_valid(iv0), .in_ready(ir0), .in_ctrl(in_ctrl), .in_data(in_data), .in_tag(in_tag),
        .flush(fl0),
        .out_valid(ov0), .out_ready(or0), .out_ctrl(oc0), .out_data(od0), .out_tag(ot0),
        .occupancy(occ0)
    );

    // Advance one clock; the model is a FIFO of capacity 2 (SKID=1) or 1 (SKID=0)
    task automatic tick();
        ent_t cur;
        bit a1, d1, a0, d0;
        cur = '{c: in_ctrl, d: in_data, t: in_tag};
        a1 = iv1 && (m1.size() < 2);
        d1 = (m1.size() > 0) && or1;
        a0 = iv0 && (or0 || (m0.size() == 0));
        d0 = (m0.size() > 0) && or0;
        @(posedge clk);
        if (fl1) m1.delete();
        else begin
            if (d1) void'(m1.pop_front());
            if (a1) m1.push_back(cur);
        end
        if (fl0) m0.delete();
        else begin
            if (d0) void'(m0.pop_front());
            if (a0) m0.push_back(cur);
        end
        #1;
    endtask

    task automatic set_pl(input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_ctrl = c;
        in_data = d;
        in_tag  = d[TW-1:0] ^ 12'h5A5;
    endtask

    task automatic test_reset();
        tests++; if (ov1 !== 1'b0)  begin fails++; $display("FAIL reset_out_valid1: got %b want 0", ov1); end
        tests++; if (oc1 !== 4'h0)  begin fails++; $display("FAIL reset_out_ctrl1: got %h want 0", oc1); end
        tests++; if (od1 !== '0)    begin fails++; $display("FAIL reset_out_data1: got %h want 0", od1); end
        tests++; if (ot1 !== '0)    begin fails++; $display("FAIL reset_out_tag1: got %h want 0", ot1); end
        tests++; if (occ1 !== 2'd0) begin fails++; $display("FAIL reset_occ1: got %0d want 0", occ1); end
        tests++; if (ir1 !== 1'b1)  begin fails++; $display("FAIL reset_in_ready1: got %b want 1", ir1); end
        tests++; if (ov0 !== 1'b0)  begin fails++; $display("FAIL reset_out_valid0: got %b want 0", ov0); end
        tests++; if (occ0 !== 2'd0) begin fails++; $display("FAIL reset_occ0: got %0d want 0", occ0); end
        tests++; if (ir0 !== 1'b1)  begin fails++; $display("FAIL reset_in_ready0: got %b want 1", ir0); end
    endtask

    task automatic test_stream();
        iv1 = 1'b1; or1 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_pl(4'h2, DW'(i));
            tick();
            tests++; if (ov1 !== 1'b1)   begin fails++; $display("FAIL stream_valid[%0d]: got %b want 1", i, ov1); end
            tests++; if (od1 !== DW'(i)) begin fails++; $display("FAIL stream_data[%0d]: got %0h want %0h", i, od1, i); end
            tests++; if (ir1 !== 1'b1)   begin fails++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, ir1); end
            tests++; if (occ1 !== 2'd1)  begin fails++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, occ1); end
        end
        iv1 = 1'b0;
        tick();
        tests++; if (ov1 !== 1'b0) begin fails++; $display("FAIL stream_empty_valid: got %b want 0", ov1); end
    endtask

    task automatic test_stall_fill();
        or1 = 1'b0; iv1 = 1'b1;
        set_pl(4'h1, DW'('hA)); tick();
        set_pl(4'h1, DW'('hB)); tick();
        iv1 = 1'b0;
        tests++; if (occ1 !== 2'd2)     begin fails++; $display("FAIL stall_occ: got %0d want 2", occ1); end
        tests++; if (ir1 !== 1'b0)      begin fails++; $display("FAIL stall_in_ready: got %b want 0", ir1); end
        tests++; if (od1 !== DW'('hA))  begin fails++; $display("FAIL stall_head: got %0h want a", od1); end
        or1 = 1'b1;
        tick();
        tests++; if (od1 !== DW'('hB))  begin fails++; $display("FAIL stall_second: got %0h want b", od1); end
        tests++; if (ir1 !== 1'b1)      begin fails++; $display("FAIL stall_ready_back: got %b want 1", ir1); end
        tests++; if (occ1 !== 2'd1)     begin fails++; $display("FAIL stall_occ_after: got %0d want 1", occ1); end
        tick();
        tests++; if (ov1 !== 1'b0)      begin fails++; $display("FAIL stall_drained: got %b want 0", ov1); end
    endtask

    task automatic test_flush();
        or1 = 1'b0; iv1 = 1'b1;
        set_pl(4'h5, DW'('hA)); tick();
        set_pl(4'h5, DW'('hB)); tick();
        set_pl(4'h7, DW'('hC)); fl1 = 1'b1;
        tick();
        fl1 = 1'b0; iv1 = 1'b0;
        tests++; if (ov1 !== 1'b0)  begin fails++; $display("FAIL flush_valid: got %b want 0", ov1); end
        tests++; if (oc1 !== 4'h0)  begin fails++; $display("FAIL flush_ctrl: got %h want 0", oc1); end
        tests++; if (occ1 !== 2'd0) begin fails++; $display("FAIL flush_occ: got %0d want 0", occ1); end
        tests++; if (ir1 !== 1'b1)  begin fails++; $display("FAIL flush_in_ready: got %b want 1", ir1); end
        or1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (ov1 !== 1'b0) begin fails++; $display("FAIL flush_no_c[%0d]: got %b want 0", i, ov1); end
        end
        // Flush while an accept is actually taken: the new entry is discarded
        or1 = 1'b0; iv1 = 1'b1;
        set_pl(4'h3, DW'('hE)); tick();
        set_pl(4'h3, DW'('hC)); fl1 = 1'b1;
        tests++; if (ir1 !== 1'b1) begin fails++; $display("FAIL flush_acc_ready: got %b want 1", ir1); end
        tick();
        fl1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;
        tests++; if (ov1 !== 1'b0)  begin fails++; $display("FAIL flush_acc_valid: got %b want 0", ov1); end
        tests++; if (occ1 !== 2'd0) begin fails++; $display("FAIL flush_acc_occ: got %0d want 0", occ1); end
        tick();
        tests++; if (ov1 !== 1'b0)  begin fails++; $display("FAIL flush_acc_later: got %b want 0", ov1); end
    endtask

    task automatic test_bubble();
        or1 = 1'b1; iv1 = 1'b1;
        set_pl(4'hF, DW'(5)); tick();
        tests++; if (ov1 !== 1'b1) begin fails++; $display("FAIL bubble_valid: got %b want 1", ov1); end
        tests++; if (oc1 !== 4'hF) begin fails++; $display("FAIL bubble_ctrl_live: got %h want f", oc1); end
        iv1 = 1'b0;
        tick();
        tests++; if (ov1 !== 1'b0) begin fails++; $display("FAIL bubble_gone: got %b want 0", ov1); end
        tests++; if (oc1 !== 4'h0) begin fails++; $display("FAIL bubble_ctrl_zero: got %h want 0", oc1); end
    endtask

    task automatic test_skid0_stall();
        iv0 = 1'b1; or0 = 1'b0;
        set_pl(4'h3, DW'(7)); tick();
        iv0 = 1'b0; #1;
        tests++; if (ov0 !== 1'b1)  begin fails++; $display("FAIL s0_valid: got %b want 1", ov0); end
        tests++; if (ir0 !== 1'b0)  begin fails++; $display("FAIL s0_stall_ready: got %b want 0", ir0); end
        tests++; if (occ0 !== 2'd1) begin fails++; $display("FAIL s0_occ: got %0d want 1", occ0); end
        or0 = 1'b1; iv0 = 1'b1; set_pl(4'h6, DW'('hD)); #1;
        tests++; if (ir0 !== 1'b1)  begin fails++; $display("FAIL s0_comb_ready: got %b want 1", ir0); end
        tick();
        tests++; if (od0 !== DW'('hD)) begin fails++; $display("FAIL s0_data: got %0h want d", od0); end
        tests++; if (oc0 !== 4'h6)  begin fails++; $display("FAIL s0_ctrl: got %h want 6", oc0); end
        iv0 = 1'b0;
        tick();
        tests++; if (ov0 !== 1'b0)  begin fails++; $display("FAIL s0_drained: got %b want 0", ov0); end
        tests++; if (oc0 !== 4'h0)  begin fails++; $display("FAIL s0_bubble_ctrl: got %h want 0", oc0); end
    endtask

    task automatic test_async_reset();
        or1 = 1'b0; iv1 = 1'b1;
        set_pl(4'h9, DW'('h11)); tick();
        set_pl(4'h9, DW'('h22)); tick();
        iv1 = 1'b0;
        tests++; if (occ1 !== 2'd2) begin fails++; $display("FAIL areset_pre_occ: got %0d want 2", occ1); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++; if (ov1 !== 1'b0)  begin fails++; $display("FAIL areset_valid: got %b want 0", ov1); end
        tests++; if (occ1 !== 2'd0) begin fails++; $display("FAIL areset_occ: got %0d want 0", occ1); end
        tests++; if (oc1 !== 4'h0)  begin fails++; $display("FAIL areset_ctrl: got %h want 0", oc1); end
        tests++; if (od1 !== '0)    begin fails++; $display("FAIL areset_data: got %h want 0", od1); end
        tests++; if (ir1 !== 1'b1)  begin fails++; $display("FAIL areset_in_ready: got %b want 1", ir1); end
        m1.delete();
        m0.delete();
        #1;
        rst = 1'b0;
        or1 = 1'b1;
        tick();
        tests++; if (ov1 !== 1'b0)  begin fails++; $display("FAIL areset_after: got %b want 0", ov1); end
    endtask

    task automatic test_random();
        logic          e_v;
        logic [CW-1:0] e_c;
        for (int i = 0; i < 400; i++) begin
            iv1 = 1'($urandom_range(0, 3) != 0);
            or1 = 1'($urandom_range(0, 2) != 0);
            fl1 = 1'($urandom_range(0, 15) == 0);
            iv0 = 1'($urandom_range(0, 3) != 0);
            or0 = 1'($urandom_range(0, 2) != 0);
            fl0 = 1'($urandom_range(0, 15) == 0);
            set_pl(CW'($urandom), {$urandom, $urandom, $urandom});
            tick();
            e_v = (m1.size() > 0);
            e_c = e_v ? m1[0].c : '0;
            tests++; if (ov1 !== e_v)  begin fails++; $display("FAIL rnd1_valid[%0d]: got %b want %b", i, ov1, e_v); end
            tests++; if (oc1 !== e_c)  begin fails++; $display("FAIL rnd1_ctrl[%0d]: got %h want %h", i, oc1, e_c); end
            tests++; if (occ1 !== 2'(m1.size())) begin fails++; $display("FAIL rnd1_occ[%0d]: got %0d want %0d", i, occ1, m1.size()); end
            tests++; if (ir1 !== (m1.size() < 2)) begin fails++; $display("FAIL rnd1_ready[%0d]: got %b want %b", i, ir1, m1.size() < 2); end
            if (e_v) begin
                tests++; if (od1 !== m1[0].d) begin fails++; $display("FAIL rnd1_data[%0d]: got %h want %h", i, od1, m1[0].d); end
                tests++; if (ot1 !== m1[0].t) begin fails++; $display("FAIL rnd1_tag[%0d]: got %h want %h", i, ot1, m1[0].t); end
            end
            e_v = (m0.size() > 0);
            e_c = e_v ? m0[0].c : '0;
            tests++; if (ov0 !== e_v)  begin fails++; $display("FAIL rnd0_valid[%0d]: got %b want %b", i, ov0, e_v); end
            tests++; if (oc0 !== e_c)  begin fails++; $display("FAIL rnd0_ctrl[%0d]: got %h want %h", i, oc0, e_c); end
            tests++; if (occ0 !== 2'(m0.size())) begin fails++; $display("FAIL rnd0_occ[%0d]: got %0d want %0d", i, occ0, m0.size()); end
            tests++; if (ir0 !== (or0 || !e_v)) begin fails++; $display("FAIL rnd0_ready[%0d]: got %b want %b", i, ir0, or0 || !e_v); end
            if (e_v) begin
                tests++; if (od0 !== m0[0].d) begin fails++; $display("FAIL rnd0_data[%0d]: got %h want %h", i, od0, m0[0].d); end
                tests++; if (ot0 !== m0[0].t) begin fails++; $display("FAIL rnd0_tag[%0d]: got %h want %h", i, ot0, m0[0].t); end
            end
        end
        iv1 = 1'b0; iv0 = 1'b0; fl1 = 1'b0; fl0 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        iv1 = 1'b0; or1 = 1'b0; fl1 = 1'b0;
        iv0 = 1'b0; or0 = 1'b0; fl0 = 1'b0;
        set_pl('0, '0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_stream();
        test_stall_fill();
        test_flush();
        test_bubble();
        test_skid0_stall();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised, elastic successor to the fixed EX/MEM pipeline register.
- Carries one pipeline stage's control bits, data words and register tags from one stage to the next. Generalised in width, and adds valid/ready handshaking, stall back-pressure, flush-to-bubble and an optional 2-entry skid so upstream ready is fully registered.
- Instantiated between any two stages (D/E, E/M, M/W) of the core.

Parameters:
- CTRL_W, 4, control-bit field width (e.g. PCSrc, RegWrite, MemWrite, MemtoReg).
- DATA_W, 96, data payload width (e.g. ALUOut, WriteData, RD2 concatenated).
- TAG_W, 12, register-tag field width (e.g. WA3, RA1, RA2).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- CLK, in, 1, rising-edge clock.
- RESET, in, 1, asynchronous active-high reset.
- in_valid, in, 1, upstream stage holds a valid instruction.
- in_ready, out, 1, buffer accepts this cycle.
- in_ctrl, in, CTRL_W, control bits.
- in_data, in, DATA_W, data payload.
- in_tag, in, TAG_W, register tags.
- flush, in, 1, kill all held entries (branch taken / exception).
- out_valid, out, 1, output entry valid.
- out_ready, in, 1, downstream accepts (0 = stall).
- out_ctrl, out, CTRL_W, control bits; forced to 0 whenever out_valid=0.
- out_data, out, DATA_W, data payload.
- out_tag, out, TAG_W, register tags.
- occupancy, out, 2, number of valid entries (0..2; max 1 when SKID=0).

Behaviour:
- Reset (async, RESET=1): all valids 0, all ctrl/data/tag registers 0, occupancy=0, out_* all 0. For SKID=1, in_ready=1 in reset. For SKID=0, in_ready is the combinational value below.
- Accept condition: in_valid && in_ready. Drain condition: out_valid && out_ready. Both are evaluated at the rising edge of CLK.
- Latency: an accepted entry appears on out_* the next cycle if the main register is empty or draining.
- Order is strictly FIFO. No entry is duplicated or dropped, except by flush.
- SKID=0:
  - in_ready = out_ready || !out_valid (combinational).
  - On accept, the main register loads the input.
  - On drain with no accept, out_valid goes to 0.
  - Stall (out_ready=0, out_valid=1): the main register holds and in_ready=0.
- SKID=1: in_ready = !skid_valid, driven directly from a flop.
  - Main empty, or draining: accepted entry goes to main. If skid was valid while main drains, skid moves to main and the new entry goes to skid.
  - Main full and not draining: accepted entry goes to skid. in_ready becomes 0 the next cycle.
  - Skid valid and main drains with no accept: skid moves to main, skid_valid becomes 0, in_ready becomes 1.
- Flush:
  - Synchronous; has highest priority.
  - Next cycle, main and skid valids are 0, their ctrl fields are 0, and occupancy=0.
  - Any simultaneous accept is discarded, and upstream sees it as consumed.
  - Any simultaneous drain still completes downstream this cycle.
  - Data/tag fields may retain stale values.
- Bubble rule: out_ctrl is 0 whenever out_valid=0, so a bubble never writes the register file or memory.
- Reset mid-operation clears everything immediately, without waiting for a clock edge.
- occupancy = main_valid + skid_valid, registered.

Decomposition:
- Shared package pipe_pkg holds the default widths (CTRL_W=4, DATA_W=96, TAG_W=12) and the E/M field-offset constants, so that stage wrappers slice the buses consistently.
- Natural sub-module: pipe_entry_reg, one valid + ctrl + data + tag register with load/clear. It is instantiated twice (main, skid) when SKID=1 and once when SKID=0.

Test Plan:
- Reset then stream (SKID=1): in_valid=1 and out_ready=1 for 4 cycles with in_data=1,2,3,4 -> out_data=1,2,3,4 one cycle later; in_ready stays 1; occupancy=1.
- Stall fill: out_ready=0 while accepting 0xA then 0xB -> occupancy=2, in_ready=0, out_data=0xA held. Raise out_ready -> 0xA then 0xB emerge; in_ready=1 one cycle after the first drain.
- Flush with full buffer: occupancy=2 plus in_valid=1 (0xC) and flush=1 -> next cycle out_valid=0, out_ctrl=4'b0000, occupancy=0; 0xC never appears.
- Bubble gating: in_ctrl=4'b1111 accepted and drained, then in_valid=0 -> out_valid=0 and out_ctrl=0 on the following cycle.
- SKID=0 stall: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle. Set out_ready=1 with in_valid=1 (0xD) -> in_ready=1 combinationally; out_data=0xD next cycle.
- Async reset mid-stall: assert RESET between edges with occupancy=2 -> out_valid, occupancy and out_ctrl go to 0 before the next edge; in_ready=1 (SKID=1).
